// File: rtl/lcd_bus_sequencer.sv
// Turns each EN rising edge of the level-held LCD command word into one HD44780 write cycle.
// Define LCD_INIT_EN to add the power-up wait and internal initialisation sequence.
module lcd_bus_sequencer #(
  parameter int T_SETUP      = 3,
  parameter int T_PULSE      = 25,
  parameter int T_HOLD       = 2,
  parameter int T_EXEC_SHORT = 2000,
  parameter int T_EXEC_LONG  = 82000,
  parameter int T_PWRUP      = 750000,
  parameter int CNT_W        = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] cmd_word,
  input  logic        ovr_clr,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on,
  output logic        lcd_blon,
  output logic        busy,
  output logic        init_done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_WAIT, S_SETUP, S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic             r_en_q, r_rs, r_on, r_blon, r_init_done, r_ovr;
  logic [7:0]       r_data;
  logic             r_pend_valid, r_pend_rs;
  logic [7:0]       r_pend_data;
  logic             w_req, w_exit, w_long, w_try_launch;
  logic             w_load, w_load_rs, w_launch_cmd, w_launch_pend;
  logic [7:0]       w_load_data;
  logic             w_stash, w_drop;
  logic             w_unused_rw;

`ifdef LCD_INIT_EN
  logic [2:0] r_init_idx, w_init_idx_nxt;
  logic       w_set_init_done;

  function automatic logic [7:0] initCmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: initCmd = 8'h38;
      3'd3:             initCmd = 8'h0C;
      3'd4:             initCmd = 8'h01;
      default:          initCmd = 8'h06;
    endcase
  endfunction
`endif

  assign w_req       = cmd_word[10] & ~r_en_q;
  assign w_exit      = (r_timer == CNT_W'(1));
  assign w_long      = ~r_rs & (r_data[7:2] == 6'd0);
  assign w_unused_rw = cmd_word[8];

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = (r_timer != '0) ? r_timer - CNT_W'(1) : '0;
    w_try_launch  = 1'b0;
    w_load        = 1'b0;
    w_load_rs     = r_rs;
    w_load_data   = r_data;
    w_launch_cmd  = 1'b0;
    w_launch_pend = 1'b0;
`ifdef LCD_INIT_EN
    w_init_idx_nxt  = r_init_idx;
    w_set_init_done = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef LCD_INIT_EN
        if (!r_init_done) begin
          w_state_nxt = S_INIT_WAIT;
          w_timer_nxt = CNT_W'(T_PWRUP);
        end else begin
          w_try_launch = 1'b1;
        end
`else
        w_try_launch = 1'b1;
`endif
      end
`ifdef LCD_INIT_EN
      S_INIT_WAIT: if (w_exit) begin
        w_state_nxt    = S_SETUP;
        w_timer_nxt    = CNT_W'(T_SETUP);
        w_load         = 1'b1;
        w_load_rs      = 1'b0;
        w_load_data    = initCmd(3'd0);
        w_init_idx_nxt = 3'd0;
      end
`endif
      S_SETUP: if (w_exit) begin
        w_state_nxt = S_PULSE;
        w_timer_nxt = CNT_W'(T_PULSE);
      end
      S_PULSE: if (w_exit) begin
        w_state_nxt = S_HOLD;
        w_timer_nxt = CNT_W'(T_HOLD);
      end
      S_HOLD: if (w_exit) begin
        w_state_nxt = S_WAIT;
        w_timer_nxt = w_long ? CNT_W'(T_EXEC_LONG) : CNT_W'(T_EXEC_SHORT);
      end
      S_WAIT: if (w_exit) begin
`ifdef LCD_INIT_EN
        if (!r_init_done && r_init_idx != 3'd5) begin
          w_state_nxt    = S_SETUP;
          w_timer_nxt    = CNT_W'(T_SETUP);
          w_load         = 1'b1;
          w_load_rs      = 1'b0;
          w_load_data    = initCmd(r_init_idx + 3'd1);
          w_init_idx_nxt = r_init_idx + 3'd1;
        end else begin
          w_set_init_done = ~r_init_done;
          w_try_launch    = 1'b1;
        end
`else
        w_try_launch = 1'b1;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Pending word goes first; a fresh request launches directly only when nothing is queued.
    if (w_try_launch) begin
      if (r_pend_valid) begin
        w_launch_pend = 1'b1;
        w_load        = 1'b1;
        w_load_rs     = r_pend_rs;
        w_load_data   = r_pend_data;
      end else if (w_req) begin
        w_launch_cmd = 1'b1;
        w_load       = 1'b1;
        w_load_rs    = cmd_word[9];
        w_load_data  = cmd_word[7:0];
      end else begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
      if (w_launch_pend || w_launch_cmd) begin
        w_state_nxt = S_SETUP;
        w_timer_nxt = CNT_W'(T_SETUP);
      end
    end
  end

  assign w_drop  = w_req & ~w_launch_cmd & r_pend_valid & ~w_launch_pend;
  assign w_stash = w_req & ~w_launch_cmd & ~w_drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_en_q      <= 1'b1;
      r_data      <= 8'h00;
      r_rs        <= 1'b0;
      r_on        <= 1'b0;
      r_blon      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_en_q  <= cmd_word[10];
      r_on    <= 1'b1;
      r_blon  <= cmd_word[11];
`ifdef LCD_INIT_EN
      if (w_set_init_done) r_init_done <= 1'b1;
`else
      r_init_done <= 1'b1;
`endif
      if (w_load) begin
        r_data <= w_load_data;
        r_rs   <= w_load_rs;
      end
    end
  end

`ifdef LCD_INIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_init_idx <= 3'd0;
    else        r_init_idx <= w_init_idx_nxt;
  end
`endif

  // A request landing on the launch cycle refills the slot the launching word just vacated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_valid <= 1'b0;
      r_pend_rs    <= 1'b0;
      r_pend_data  <= 8'h00;
      r_ovr        <= 1'b0;
    end else begin
      if (w_stash) begin
        r_pend_valid <= 1'b1;
        r_pend_rs    <= cmd_word[9];
        r_pend_data  <= cmd_word[7:0];
      end else if (w_launch_pend) begin
        r_pend_valid <= 1'b0;
      end
      if (w_drop)       r_ovr <= 1'b1;
      else if (ovr_clr) r_ovr <= 1'b0;
    end
  end

  assign lcd_data  = r_data;
  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = (r_state == S_PULSE);
  assign lcd_on    = r_on;
  assign lcd_blon  = r_blon;
  assign busy      = (r_state != S_IDLE);
  assign init_done = r_init_done;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed self-checking bench for lcd_bus_sequencer with shortened timing parameters.
// Define LCD_INIT_EN to exercise the power-up init sequence instead of the plain reset release.
module tb_lcd_bus_sequencer;
  localparam int T_SETUP = 2, T_PULSE = 4, T_HOLD = 2, T_SHORT = 10, T_LONG = 50, T_PWRUP = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cmd_word = 12'hC38;
  logic        ovr_clr = 1'b0;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, init_done, overrun;
  int          nChecks = 0, nPass = 0, nFail = 0;

  always #5 clk = ~clk;

  lcd_bus_sequencer #(
    .T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD),
    .T_EXEC_SHORT(T_SHORT), .T_EXEC_LONG(T_LONG), .T_PWRUP(T_PWRUP), .CNT_W(20)
  ) dut (
    .clk(clk), .reset(reset), .cmd_word(cmd_word), .ovr_clr(ovr_clr),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon), .busy(busy), .init_done(init_done),
    .overrun(overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives a new word at a falling edge; the next rising edge is the request cycle (cycle 0).
  task automatic applyStimulus(input logic [11:0] word);
    @(negedge clk);
    cmd_word = word;
  endtask

  task automatic measureCycle(input logic [7:0] expData, input logic expRs,
                              output int enFirst, output int enLast, output int enCount,
                              output int busyLen, output int pinErrs);
    enFirst = 0; enLast = 0; enCount = 0; busyLen = 0; pinErrs = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (!busy) break;
      busyLen++;
      if (lcd_en) begin
        if (enFirst == 0) enFirst = k;
        enLast = k;
        enCount++;
      end
      if (k <= T_SETUP + T_PULSE + T_HOLD && (lcd_data !== expData || lcd_rs !== expRs)) pinErrs++;
    end
  endtask

`ifdef LCD_INIT_EN
  logic [7:0] pulseData [0:7];
  logic       pulseRs [0:7];
`endif

  initial begin
    int enFirst, enLast, enCount, busyLen, pinErrs, enSeen, busySeen, gap;
    logic ovr9, ovr10, en19;
    logic [7:0] d18, d19, d36, d37;
`ifdef LCD_INIT_EN
    int pulses, firstEn;
    logic prevEn, doneAtLastInit;
`endif

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", lcd_data, 8'h00);
    checkOutput("rst_rs", lcd_rs, 1'b0);
    checkOutput("rst_en", lcd_en, 1'b0);
    checkOutput("rst_on", lcd_on, 1'b0);
    checkOutput("rst_blon", lcd_blon, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);

`ifdef LCD_INIT_EN
    cmd_word = 12'h000;
    reset = 1'b1;
    pulses = 0; firstEn = 0; prevEn = 1'b0; doneAtLastInit = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (lcd_en && !prevEn) begin
        if (pulses < 8) begin
          pulseData[pulses] = lcd_data;
          pulseRs[pulses] = lcd_rs;
        end
        if (pulses == 5) doneAtLastInit = init_done;
        if (firstEn == 0) firstEn = k;
        pulses++;
      end
      prevEn = lcd_en;
      if (k == 20) cmd_word = 12'hE41;
      if (k == 21) cmd_word = 12'hA41;
    end
    checkOutput("init_quiet_100", (firstEn > T_PWRUP), 1'b1);
    checkOutput("init_pulses", pulses, 7);
    checkOutput("init_d0", pulseData[0], 8'h38);
    checkOutput("init_d1", pulseData[1], 8'h38);
    checkOutput("init_d2", pulseData[2], 8'h38);
    checkOutput("init_d3", pulseData[3], 8'h0C);
    checkOutput("init_d4", pulseData[4], 8'h01);
    checkOutput("init_d5", pulseData[5], 8'h06);
    checkOutput("init_rs", {pulseRs[0], pulseRs[1], pulseRs[2], pulseRs[3], pulseRs[4], pulseRs[5]}, 6'b0);
    checkOutput("init_done_during", doneAtLastInit, 1'b0);
    checkOutput("init_done_after", init_done, 1'b1);
    checkOutput("init_req_data", pulseData[6], 8'h41);
    checkOutput("init_req_rs", pulseRs[6], 1'b1);
    checkOutput("init_busy_end", busy, 1'b0);
`else
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_on", lcd_on, 1'b1);
    checkOutput("post_rst_init_done", init_done, 1'b1);
    checkOutput("post_rst_blon", lcd_blon, 1'b1);
    enSeen = 0; busySeen = 0;
    repeat (10) begin
      @(negedge clk);
      if (lcd_en) enSeen++;
      if (busy) busySeen++;
    end
    checkOutput("held_en_no_pulse", enSeen, 0);
    checkOutput("held_en_no_busy", busySeen, 0);
`endif

    // EN-low words only move the backlight.
    enSeen = 0;
    applyStimulus(12'h800); @(negedge clk); if (lcd_en) enSeen++;
    checkOutput("blon_on", lcd_blon, 1'b1);
    applyStimulus(12'h000); @(negedge clk); if (lcd_en) enSeen++;
    checkOutput("blon_off", lcd_blon, 1'b0);
    applyStimulus(12'h800); @(negedge clk); if (lcd_en) enSeen++;
    applyStimulus(12'h000); @(negedge clk); if (lcd_en) enSeen++;
    checkOutput("blon_off2", lcd_blon, 1'b0);
    checkOutput("en0_no_pulse", enSeen + int'(busy), 0);

    applyStimulus(12'hE41);
    measureCycle(8'h41, 1'b1, enFirst, enLast, enCount, busyLen, pinErrs);
    checkOutput("data_en_first", enFirst, 3);
    checkOutput("data_en_last", enLast, 6);
    checkOutput("data_en_count", enCount, 4);
    checkOutput("data_busy_len", busyLen, 18);
    checkOutput("data_pins", pinErrs, 0);
    checkOutput("data_blon", lcd_blon, 1'b1);
    checkOutput("data_rw", lcd_rw, 1'b0);
    applyStimulus(12'hA41);
    @(negedge clk);
    checkOutput("idle_hold_data", lcd_data, 8'h41);
    checkOutput("idle_hold_rs", lcd_rs, 1'b1);

    applyStimulus(12'hC01);
    measureCycle(8'h01, 1'b0, enFirst, enLast, enCount, busyLen, pinErrs);
    checkOutput("clear_busy_len", busyLen, 58);
    checkOutput("clear_pins", pinErrs, 0);
    applyStimulus(12'h801);
    applyStimulus(12'hC0C);
    measureCycle(8'h0C, 1'b0, enFirst, enLast, enCount, busyLen, pinErrs);
    checkOutput("disp_on_busy_len", busyLen, 18);
    applyStimulus(12'h80C);

    // Back-to-back: second word queued, third dropped.
    applyStimulus(12'hE41);
    busyLen = 0; gap = 0; enCount = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!busy) gap = 1;
      else if (gap == 0) busyLen++;
      if (lcd_en) enCount++;
      if (k == 9) ovr9 = overrun;
      if (k == 10) ovr10 = overrun;
      if (k == 18) d18 = lcd_data;
      if (k == 19) begin d19 = lcd_data; en19 = lcd_en; end
      case (k)
        1:  cmd_word = 12'hA41;
        5:  cmd_word = 12'hE42;
        6:  cmd_word = 12'hA42;
        9:  cmd_word = 12'hE43;
        10: cmd_word = 12'hA43;
        default: ;
      endcase
    end
    checkOutput("b2b_busy_len", busyLen, 36);
    checkOutput("b2b_ovr_before", ovr9, 1'b0);
    checkOutput("b2b_ovr_set", ovr10, 1'b1);
    checkOutput("b2b_d18", d18, 8'h41);
    checkOutput("b2b_d19", d19, 8'h42);
    checkOutput("b2b_en19", en19, 1'b0);
    checkOutput("b2b_en_count", enCount, 8);
    checkOutput("b2b_final_data", lcd_data, 8'h42);
    checkOutput("b2b_ovr_sticky", overrun, 1'b1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    checkOutput("ovr_clr", overrun, 1'b0);

    // A request on the launch cycle refills the pending slot without overrun.
    applyStimulus(12'hE51);
    busyLen = 0; gap = 0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (!busy) gap = 1;
      else if (gap == 0) busyLen++;
      if (k == 36) d36 = lcd_data;
      if (k == 37) d37 = lcd_data;
      case (k)
        1:  cmd_word = 12'hA51;
        2:  cmd_word = 12'hE52;
        3:  cmd_word = 12'hA52;
        18: cmd_word = 12'hE53;
        19: cmd_word = 12'hA53;
        default: ;
      endcase
    end
    checkOutput("refill_busy_len", busyLen, 54);
    checkOutput("refill_d36", d36, 8'h52);
    checkOutput("refill_d37", d37, 8'h53);
    checkOutput("refill_no_ovr", overrun, 1'b0);

    // Reset mid-PULSE with a word pending.
    applyStimulus(12'hE41);
    @(negedge clk); cmd_word = 12'hA41;
    @(negedge clk); cmd_word = 12'hE42;
    @(negedge clk); cmd_word = 12'hA42;
    @(negedge clk);
    checkOutput("mid_pulse_en", lcd_en, 1'b1);
    reset = 1'b0;
    #1;
    checkOutput("async_en_drop", lcd_en, 1'b0);
    checkOutput("async_busy_drop", busy, 1'b0);
    checkOutput("async_data_clr", lcd_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
`ifndef LCD_INIT_EN
    busySeen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busySeen++;
    end
    checkOutput("pending_lost", busySeen, 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
